// File: rtl/tag_serializer.sv
// Buffers {chan, time} tag records in a small FIFO and sends each one as a 5-byte,
// MSB-first packet to one writer port of the host output mux. Overflow drops are counted.
module tag_serializer #(
    parameter int FIFO_AW = 4
) (
    input  logic               clk_i,
    input  logic               nreset_i,
    input  logic [35:0]        tag_time_i,
    input  logic [3:0]         tag_chan_i,
    input  logic               tag_strobe_i,
    input  logic               enable_i,
    input  logic               lost_clr_i,
    output logic [7:0]         omux_data_o,
    output logic               omux_req_o,
    input  logic               omux_sel_i,
    output logic [15:0]        lost_o,
    output logic [FIFO_AW:0]   fifo_level_o
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0]   FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_ONE    = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_t;

    state_t              state_reg, state_next;
    logic [39:0]         shift_reg, shift_next;
    logic [2:0]          cnt_reg, cnt_next;

    logic [39:0]         mem [DEPTH];
    logic [39:0]         rd_data_reg;
    logic [FIFO_AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_AW:0]    level_reg;
    logic [15:0]         lost_reg;

    logic                full;
    logic                empty;
    logic                push;
    logic                drop;
    logic                pop;

    // Full is judged on the pre-pop level, so a write while full is lost even on a pop cycle.
    assign full  = (level_reg == FULL_LEVEL);
    assign empty = (level_reg == '0);
    assign push  = tag_strobe_i & enable_i & ~full;
    assign drop  = tag_strobe_i & enable_i & full;

    // Storage has no reset so it maps onto block RAM; the read port is registered.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_reg] <= {tag_chan_i, tag_time_i};
        end
        if (pop) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + LVL_ONE;
                2'b01:   level_reg <= level_reg - LVL_ONE;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // A clear coinciding with a drop leaves exactly that one drop counted.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            lost_reg <= '0;
        end else if (lost_clr_i) begin
            lost_reg <= drop ? 16'd1 : 16'd0;
        end else if (drop && (lost_reg != 16'hFFFF)) begin
            lost_reg <= lost_reg + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_reg <= ST_IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_next = rd_data_reg;
                cnt_next   = 3'd0;
                state_next = ST_SEND;
            end
            ST_SEND: begin
                if (omux_sel_i) begin
                    shift_next = {shift_reg[31:0], 8'h00};
                    cnt_next   = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd4) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request is the SEND state itself, so it falls with the asynchronous reset.
    // The byte path is combinational from sel: the mux samples in the cycle it grants.
    assign omux_req_o   = (state_reg == ST_SEND);
    assign omux_data_o  = (omux_sel_i && (state_reg == ST_SEND)) ? shift_reg[39:32] : 8'h00;
    assign lost_o       = lost_reg;
    assign fifo_level_o = level_reg;

endmodule
